// File: rtl/cv_pad_pkg.sv
// cv_pad_pkg: shared definitions for the ColecoVision-style controller interface.
// Holds the button flag layout, joy bit indices, keypad codes, the PS/2 scan-code
// key map, the spinner state enum and small helper functions.
package cv_pad_pkg;

  // Button flag layout: bits 0..11 line up with joy bits 0..11.
  localparam int unsigned NUM_BTN  = 20;
  localparam int unsigned B_R      = 0;
  localparam int unsigned B_L      = 1;
  localparam int unsigned B_D      = 2;
  localparam int unsigned B_U      = 3;
  localparam int unsigned B_FIRE   = 4;
  localparam int unsigned B_ARM    = 5;
  localparam int unsigned B_STAR   = 6;
  localparam int unsigned B_HASH   = 7;
  localparam int unsigned B_K0     = 8;   // keys 0..9 at 8..17
  localparam int unsigned B_PURPLE = 18;
  localparam int unsigned B_BLUE   = 19;

  // joy bit indices
  localparam int unsigned J_PURPLE = 12;
  localparam int unsigned J_BLUE   = 13;
  localparam int unsigned J_SPIN_L = 14;
  localparam int unsigned J_SPIN_R = 15;

  // Keypad codes as {p1,p2,p3,p4}
  localparam logic [3:0] KP_0    = 4'b0011;
  localparam logic [3:0] KP_1    = 4'b1110;
  localparam logic [3:0] KP_2    = 4'b1101;
  localparam logic [3:0] KP_3    = 4'b0110;
  localparam logic [3:0] KP_4    = 4'b0001;
  localparam logic [3:0] KP_5    = 4'b1001;
  localparam logic [3:0] KP_6    = 4'b0111;
  localparam logic [3:0] KP_7    = 4'b1100;
  localparam logic [3:0] KP_8    = 4'b1000;
  localparam logic [3:0] KP_9    = 4'b1011;
  localparam logic [3:0] KP_STAR = 4'b1010;
  localparam logic [3:0] KP_HASH = 4'b0101;
  localparam logic [3:0] KP_PT   = 4'b0100;
  localparam logic [3:0] KP_BT   = 4'b0010;
  localparam logic [3:0] KP_NONE = 4'b1111;

  // Spinner states, encoded directly as {p7,p9}
  typedef enum logic [1:0] {
    SP_S0 = 2'b11,
    SP_S1 = 2'b01,
    SP_S2 = 2'b00,
    SP_S3 = 2'b10
  } spin_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } key_hit_t;

  // Scan-code (set 2) to button flag map; {extended, code}.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = '0;
    case ({ext, code})
      9'h175:         r.idx = 5'(B_U);
      9'h172:         r.idx = 5'(B_D);
      9'h16B:         r.idx = 5'(B_L);
      9'h174:         r.idx = 5'(B_R);
      9'h045, 9'h022: r.idx = 5'(B_K0);
      9'h016:         r.idx = 5'(B_K0 + 1);
      9'h01E:         r.idx = 5'(B_K0 + 2);
      9'h026:         r.idx = 5'(B_K0 + 3);
      9'h025, 9'h015: r.idx = 5'(B_K0 + 4);
      9'h02E, 9'h01D: r.idx = 5'(B_K0 + 5);
      9'h036, 9'h024: r.idx = 5'(B_K0 + 6);
      9'h03D, 9'h01C: r.idx = 5'(B_K0 + 7);
      9'h03E, 9'h01B: r.idx = 5'(B_K0 + 8);
      9'h046, 9'h023: r.idx = 5'(B_K0 + 9);
      9'h01A:         r.idx = 5'(B_STAR);
      9'h021:         r.idx = 5'(B_HASH);
      9'h11F, 9'h127: r.idx = 5'(B_PURPLE);
      9'h011, 9'h111: r.idx = 5'(B_BLUE);
      9'h014, 9'h114: r.idx = 5'(B_FIRE);
      9'h012, 9'h059: r.idx = 5'(B_ARM);
      default:        r.hit = 1'b0;
    endcase
    return r;
  endfunction

  // joy word to button flags (spinner bits handled separately)
  function automatic logic [NUM_BTN-1:0] joy_to_btn(input logic [15:0] j);
    logic [NUM_BTN-1:0] b;
    b           = '0;
    b[11:0]     = j[11:0];
    b[B_PURPLE] = j[J_PURPLE];
    b[B_BLUE]   = j[J_BLUE];
    return b;
  endfunction

  // Keypad encode, priority 0 > 1 > ... > 9 > * > # > purple > blue
  function automatic logic [3:0] keypad_code(input logic [NUM_BTN-1:0] b);
    if      (b[B_K0])     return KP_0;
    else if (b[B_K0 + 1]) return KP_1;
    else if (b[B_K0 + 2]) return KP_2;
    else if (b[B_K0 + 3]) return KP_3;
    else if (b[B_K0 + 4]) return KP_4;
    else if (b[B_K0 + 5]) return KP_5;
    else if (b[B_K0 + 6]) return KP_6;
    else if (b[B_K0 + 7]) return KP_7;
    else if (b[B_K0 + 8]) return KP_8;
    else if (b[B_K0 + 9]) return KP_9;
    else if (b[B_STAR])   return KP_STAR;
    else if (b[B_HASH])   return KP_HASH;
    else if (b[B_PURPLE]) return KP_PT;
    else if (b[B_BLUE])   return KP_BT;
    else                  return KP_NONE;
  endfunction

endpackage

// File: rtl/cv_pad_chan.sv
// cv_pad_chan: one controller port -- autofire, spinner FSM and pin encode.
// Ports: clk_i/reset_i (sync active-high), btn_i button flags, spin_l_i/spin_r_i,
// turbo_en_i, p5_n_i/p8_n_i select strobes (active low), p1..p4/p6/p7/p9 pins (active low, registered).
module cv_pad_chan
  import cv_pad_pkg::*;
#(
  parameter int unsigned TURBO_W  = 20,
  parameter int unsigned SPIN_DIV = 4096
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               spin_l_i,
  input  logic               spin_r_i,
  input  logic               turbo_en_i,
  input  logic               p5_n_i,
  input  logic               p8_n_i,
  output logic               p1_o,
  output logic               p2_o,
  output logic               p3_o,
  output logic               p4_o,
  output logic               p6_o,
  output logic               p7_o,
  output logic               p9_o
);

  localparam int unsigned SPIN_CW  = 16;
  localparam logic [SPIN_CW-1:0] DIV_MAX = SPIN_CW'(SPIN_DIV - 1);

  logic [TURBO_W-1:0] turbo_q, turbo_d;
  logic               phase_q, phase_d;
  logic [SPIN_CW-1:0] div_q, div_d;
  spin_e              spin_q, spin_d;
  logic [4:0]         pins_q, pins_d;   // {p1,p2,p3,p4,p6}
  logic               fire_eff;
  logic [3:0]         kp_nib, js_nib;
  logic               kp_p6, js_p6;

  // Autofire: phase starts high so the first pressed cycle fires at once.
  always_comb begin
    turbo_d = '0;
    phase_d = 1'b1;
    if (turbo_en_i && btn_i[B_FIRE]) begin
      turbo_d = turbo_q + TURBO_W'(1);
      phase_d = (&turbo_q) ? ~phase_q : phase_q;
    end
  end

  // Pin encode: keypad and joystick halves are ANDed when both selects are low.
  always_comb begin
    fire_eff = btn_i[B_FIRE] & phase_q;
    kp_nib   = p5_n_i ? 4'hF : keypad_code(btn_i);
    kp_p6    = p5_n_i | ~btn_i[B_ARM];
    js_nib   = p8_n_i ? 4'hF : ~{btn_i[B_U], btn_i[B_D], btn_i[B_L], btn_i[B_R]};
    js_p6    = p8_n_i | ~fire_eff;
    pins_d   = {kp_nib & js_nib, kp_p6 & js_p6};
  end

  // Spinner next state: step only while exactly one direction is held.
  always_comb begin
    spin_d = spin_q;
    div_d  = '0;
    if (spin_r_i ^ spin_l_i) begin
      if (div_q == DIV_MAX) begin
        if (spin_r_i) begin
          case (spin_q)
            SP_S0:   spin_d = SP_S1;
            SP_S1:   spin_d = SP_S2;
            SP_S2:   spin_d = SP_S3;
            default: spin_d = SP_S0;
          endcase
        end else begin
          case (spin_q)
            SP_S0:   spin_d = SP_S3;
            SP_S3:   spin_d = SP_S2;
            SP_S2:   spin_d = SP_S1;
            default: spin_d = SP_S0;
          endcase
        end
      end else begin
        div_d = div_q + SPIN_CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      turbo_q <= '0;
      phase_q <= 1'b1;
      div_q   <= '0;
      spin_q  <= SP_S0;
      pins_q  <= '1;
    end else begin
      turbo_q <= turbo_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      spin_q  <= spin_d;
      pins_q  <= pins_d;
    end
  end

  assign {p1_o, p2_o, p3_o, p4_o, p6_o} = pins_q;
  assign {p7_o, p9_o}                   = spin_q;

endmodule

// File: rtl/cv_pad_if.sv
// cv_pad_if: PS/2 keyboard and USB-style joypads to ColecoVision controller pins.
// Ports: clk_sys, reset (sync active-high), ps2_key event word, joy buttons (16 per pad),
// turbo_en, ctrl_p5_i/ctrl_p8_i select strobes, ctrl_p1_o..ctrl_p9_o pins (active low).
module cv_pad_if
  import cv_pad_pkg::*;
#(
  parameter int unsigned NUM_PADS = 2,
  parameter int unsigned TURBO_W  = 20,
  parameter int unsigned SPIN_DIV = 4096
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [64:0]           ps2_key,
  input  logic [16*NUM_PADS-1:0] joy,
  input  logic [NUM_PADS-1:0]   turbo_en,
  input  logic [NUM_PADS-1:0]   ctrl_p5_i,
  input  logic [NUM_PADS-1:0]   ctrl_p8_i,
  output logic [NUM_PADS-1:0]   ctrl_p1_o,
  output logic [NUM_PADS-1:0]   ctrl_p2_o,
  output logic [NUM_PADS-1:0]   ctrl_p3_o,
  output logic [NUM_PADS-1:0]   ctrl_p4_o,
  output logic [NUM_PADS-1:0]   ctrl_p6_o,
  output logic [NUM_PADS-1:0]   ctrl_p7_o,
  output logic [NUM_PADS-1:0]   ctrl_p9_o
);

  logic               tog_q;
  logic [NUM_BTN-1:0] keys_q, keys_d;
  logic               pressed, extended, evt;
  key_hit_t           hit;

  // Key event decode; events with anything in [63:24] (e.g. Pause) are ignored.
  always_comb begin
    pressed  = (ps2_key[15:8] != 8'hF0);
    extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    evt      = (ps2_key[64] != tog_q) && (ps2_key[63:24] == '0);
    hit      = key_lookup(extended, ps2_key[7:0]);
    keys_d   = keys_q;
    if (evt && hit.hit) begin
      keys_d[hit.idx] = pressed;
    end
  end

  // The toggle copy is also captured in reset so an event coinciding with reset is dropped.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[64];
    if (reset) begin
      keys_q <= '0;
    end else begin
      keys_q <= keys_d;
    end
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    logic [NUM_BTN-1:0] btn;

    if (i == 0) begin : g_kb
      assign btn = joy_to_btn(joy[15:0]) | keys_q;
    end else begin : g_joy
      assign btn = joy_to_btn(joy[16*i +: 16]);
    end

    cv_pad_chan #(
      .TURBO_W  (TURBO_W),
      .SPIN_DIV (SPIN_DIV)
    ) u_chan (
      .clk_i      (clk_sys),
      .reset_i    (reset),
      .btn_i      (btn),
      .spin_l_i   (joy[16*i + J_SPIN_L]),
      .spin_r_i   (joy[16*i + J_SPIN_R]),
      .turbo_en_i (turbo_en[i]),
      .p5_n_i     (ctrl_p5_i[i]),
      .p8_n_i     (ctrl_p8_i[i]),
      .p1_o       (ctrl_p1_o[i]),
      .p2_o       (ctrl_p2_o[i]),
      .p3_o       (ctrl_p3_o[i]),
      .p4_o       (ctrl_p4_o[i]),
      .p6_o       (ctrl_p6_o[i]),
      .p7_o       (ctrl_p7_o[i]),
      .p9_o       (ctrl_p9_o[i])
    );
  end

endmodule
